interrupt_controller: RTL and testbench

//  Source end of the CPU's `interrupt` input. Latches NUM_SRC peripheral requests and masks them.

---
 rtl/interrupt_controller.sv | 240 ++++++++++++++++++++++++
 tb/tb_interrupt_controller.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//
// Source end of the CPU interrupt input. Latches NUM_SRC peripheral requests
// into PENDING, qualifies them with MASK, raises one request at a time to the
// CPU together with its handler vector, and tracks the in-service source until
// the handler writes EOI. Appears as a memory-mapped slave on the data bus.
//
// Register map (offset = memAddr[3:2], memAddr[1:0] ignored):
//   0 PENDING   read, write-1-to-clear
//   1 MASK      read/write, 1 = source enabled
//   2 INSERVICE read only, one-hot or zero
//   3 EOI       write only (any data), reads zero
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   irq_src      peripheral requests, synchronous to clk
//   memAddr      CPU data address
//   memWriteData CPU store data
//   memWrite     CPU store strobe
//   memRead      CPU load strobe
//   readData     combinational register readback (zero unless sel & memRead)
//   sel          memAddr hits this register block
//   interrupt    request to CPU (decoded from the state register)
//   int_ack      CPU accepts the current request, one-cycle pulse
//   vector       handler address for the current request
//
// Build option:
//   IRQ_EDGE_DETECT_EN  when defined, a source pends only on a 0->1 transition;
//                       when undefined, a source pends on every high cycle.
// -----------------------------------------------------------------------------
module interrupt_controller #(
    parameter int          NUM_SRC   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter logic [31:0] VEC_BASE  = 32'h0000_0100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [31:0]        memAddr,
    input  logic [31:0]        memWriteData,
    input  logic               memWrite,
    input  logic               memRead,
    output logic [31:0]        readData,
    output logic               sel,
    output logic               interrupt,
    input  logic               int_ack,
    output logic [31:0]        vector
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] inservice_q, inservice_d;
    logic [4:0]         id_q, id_d;

    logic [1:0]         offset_s;
    logic               reg_wr_s;
    logic [NUM_SRC-1:0] set_s;
    logic [NUM_SRC-1:0] active_s;
    logic [NUM_SRC-1:0] id_onehot_s;
    logic [NUM_SRC-1:0] w1c_clr_s;
    logic [NUM_SRC-1:0] ack_clr_s;
    logic [4:0]         lowest_s;
    logic               any_active_s;
    logic               ack_fire_s;
    logic               eoi_fire_s;
    logic               unused_s;

    // Zero-extend a source-wide vector to the 32-bit bus (works for NUM_SRC=32).
    function automatic logic [31:0] zext(input logic [NUM_SRC-1:0] v);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < NUM_SRC; i++) begin
            r[i] = v[i];
        end
        return r;
    endfunction

    // Byte-lane bits and unused data bits are intentionally ignored.
    assign unused_s = ^{memAddr[1:0], memWriteData};

`ifdef IRQ_EDGE_DETECT_EN
    logic [NUM_SRC-1:0] prev_q, prev_d;

    // Previous sample of each source for rising-edge detection.
    always_comb begin
        prev_d = irq_src;
        set_s  = irq_src & ~prev_q;
    end

    // Source history register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= {NUM_SRC{1'b0}};
        end else begin
            prev_q <= prev_d;
        end
    end
`else
    // Level mode: every high cycle of a source (re)pends it.
    always_comb begin
        set_s = irq_src;
    end
`endif

    // Bus decode and combinational readback.
    always_comb begin
        sel      = (memAddr[31:4] == BASE_ADDR[31:4]);
        offset_s = memAddr[3:2];
        reg_wr_s = sel & memWrite;
        readData = 32'h0;
        if (sel && memRead) begin
            case (offset_s)
                2'd0:    readData = zext(pending_q);
                2'd1:    readData = zext(mask_q);
                2'd2:    readData = zext(inservice_q);
                2'd3:    readData = 32'h0;
                default: readData = 32'h0;
            endcase
        end else begin
            readData = 32'h0;
        end
    end

    // Priority pick (lowest index wins) and one-hot of the frozen id.
    always_comb begin
        active_s     = pending_q & mask_q;
        any_active_s = |active_s;
        lowest_s     = 5'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            lowest_s = active_s[i] ? 5'(i) : lowest_s;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            id_onehot_s[i] = (id_q == 5'(i));
        end
    end

    // Handshake qualification: ack only counts in REQ, EOI only in SERVICE.
    always_comb begin
        ack_fire_s = (state_q == ST_REQ) && int_ack;
        eoi_fire_s = (state_q == ST_SERVICE) && reg_wr_s && (offset_s == 2'd3);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_active_s) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_fire_s) begin
                    state_d = ST_SERVICE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (eoi_fire_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register datapath; a new set beats a same-cycle clear.
    always_comb begin
        if (reg_wr_s && (offset_s == 2'd0)) begin
            w1c_clr_s = memWriteData[NUM_SRC-1:0];
        end else begin
            w1c_clr_s = {NUM_SRC{1'b0}};
        end
        if (ack_fire_s) begin
            ack_clr_s = id_onehot_s;
        end else begin
            ack_clr_s = {NUM_SRC{1'b0}};
        end
        pending_d = (pending_q & ~(w1c_clr_s | ack_clr_s)) | set_s;

        if (reg_wr_s && (offset_s == 2'd1)) begin
            mask_d = memWriteData[NUM_SRC-1:0];
        end else begin
            mask_d = mask_q;
        end

        if (ack_fire_s) begin
            inservice_d = id_onehot_s;
        end else if (eoi_fire_s) begin
            inservice_d = {NUM_SRC{1'b0}};
        end else begin
            inservice_d = inservice_q;
        end

        // id is captured only on IDLE->REQ so the vector holds through SERVICE.
        if ((state_q == ST_IDLE) && any_active_s) begin
            id_d = lowest_s;
        end else begin
            id_d = id_q;
        end
    end

    // State and register flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pending_q   <= {NUM_SRC{1'b0}};
            mask_q      <= {NUM_SRC{1'b0}};
            inservice_q <= {NUM_SRC{1'b0}};
            id_q        <= 5'd0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            inservice_q <= inservice_d;
            id_q        <= id_d;
        end
    end

    // Outputs decoded from registered state; reset drops interrupt at once.
    always_comb begin
        interrupt = (state_q == ST_REQ);
        vector    = VEC_BASE + {25'h0, id_q, 2'b00};
    end

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

    localparam logic [31:0] A_PEND = 32'h0000_1000;
    localparam logic [31:0] A_MASK = 32'h0000_1004;
    localparam logic [31:0] A_INSV = 32'h0000_1008;
    localparam logic [31:0] A_EOI  = 32'h0000_100C;

`ifdef IRQ_EDGE_DETECT_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [7:0]  irq_src;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic        memWrite;
    logic        memRead;
    logic [31:0] readData;
    logic        sel;
    logic        interrupt;
    logic        int_ack;
    logic [31:0] vector;

    typedef struct {
        bit          irq;
        bit          chk_vec;
        logic [31:0] vec;
    } probe_t;

    logic [31:0] rd_q[$];
    logic [31:0] vec_q[$];
    probe_t      probe_q[$];
    logic        probe;
    logic        int_prev;
    int          n_cmp;
    int          n_fail;

    interrupt_controller dut (
        .clk          (clk),
        .reset        (reset),
        .irq_src      (irq_src),
        .memAddr      (memAddr),
        .memWriteData (memWriteData),
        .memWrite     (memWrite),
        .memRead      (memRead),
        .readData     (readData),
        .sel          (sel),
        .interrupt    (interrupt),
        .int_ack      (int_ack),
        .vector       (vector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops expectations whenever the DUT presents something to check.
    initial int_prev = 1'b0;
    always @(negedge clk) begin
        logic [31:0] e;
        probe_t      p;
        if (memRead) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: addr %h data %h, no read expected", memAddr, readData);
            end else begin
                e = rd_q.pop_front();
                if (readData !== e) begin
                    n_fail++;
                    $display("FAIL read@%h: got %h want %h", memAddr, readData, e);
                end
            end
        end
        if (interrupt && !int_prev) begin
            n_cmp++;
            if (vec_q.size() == 0) begin
                n_fail++;
                $display("FAIL irq_unexpected: vector %h, no request expected", vector);
            end else begin
                e = vec_q.pop_front();
                if (vector !== e) begin
                    n_fail++;
                    $display("FAIL vector: got %h want %h", vector, e);
                end
            end
        end
        if (probe) begin
            n_cmp++;
            if (probe_q.size() == 0) begin
                n_fail++;
                $display("FAIL probe_unexpected: interrupt %b", interrupt);
            end else begin
                p = probe_q.pop_front();
                if (interrupt !== p.irq || (p.chk_vec && vector !== p.vec)) begin
                    n_fail++;
                    $display("FAIL probe: got int=%b vec=%h want int=%b vec=%h (vec checked=%0d)",
                             interrupt, vector, p.irq, p.vec, p.chk_vec);
                end
            end
        end
        int_prev = interrupt;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp);
        memAddr = a;
        memRead = 1'b1;
        rd_q.push_back(exp);
        @(negedge clk);
        #1;
        memRead = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memAddr      = a;
        memWriteData = d;
        memWrite     = 1'b1;
        tick();
        memWrite     = 1'b0;
    endtask

    task automatic chk_int(input bit irq, input bit cv, input logic [31:0] v);
        probe_t p;
        p.irq     = irq;
        p.chk_vec = cv;
        p.vec     = v;
        probe_q.push_back(p);
        probe = 1'b1;
        @(negedge clk);
        #1;
        probe = 1'b0;
    endtask

    task automatic ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic wait_int(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (interrupt) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s: interrupt got 0 want 1 within 20 cycles", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_fail = 0;
        reset = 1'b0;
        irq_src = 8'h00;
        memAddr = 32'h0;
        memWriteData = 32'h0;
        memWrite = 1'b0;
        memRead = 1'b0;
        int_ack = 1'b0;
        probe = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // 1: reset values
        rd(A_PEND, 32'h0);
        rd(A_MASK, 32'h0);
        rd(A_INSV, 32'h0);
        rd(A_EOI,  32'h0);
        chk_int(1'b0, 1'b1, 32'h0000_0100);

        // 2: single source, latency and service bookkeeping
        wr(A_MASK, 32'h0000_000C);
        rd(A_MASK, 32'h0000_000C);
        rd(32'h0000_1005, 32'h0000_000C);     // byte-lane bits ignored
        rd(32'h0000_2004, 32'h0);             // outside the block
        vec_q.push_back(32'h0000_010C);
        irq_src = 8'h08;
        tick();
        irq_src = 8'h00;
        chk_int(1'b0, 1'b0, 32'h0);
        tick();
        chk_int(1'b1, 1'b1, 32'h0000_010C);
        ack();
        chk_int(1'b0, 1'b1, 32'h0000_010C);
        rd(A_INSV, 32'h0000_0008);
        rd(A_PEND, 32'h0);
        wr(A_EOI, 32'h0);
        rd(A_INSV, 32'h0);

        // 3: simultaneous sources served lowest first
        wr(A_MASK, 32'h0000_00FF);
        vec_q.push_back(32'h0000_0108);
        vec_q.push_back(32'h0000_0114);
        irq_src = 8'h24;
        tick();
        irq_src = 8'h00;
        wait_int("t3_first");
        rd(A_PEND, 32'h0000_0024);
        ack();
        rd(A_PEND, 32'h0000_0020);
        wr(A_EOI, 32'h0);
        wait_int("t3_second");
        ack();
        rd(A_INSV, 32'h0000_0020);
        wr(A_EOI, 32'h0);

        // 4: request not withdrawn by MASK write
        vec_q.push_back(32'h0000_0110);
        irq_src = 8'h10;
        tick();
        irq_src = 8'h00;
        wait_int("t4_req");
        wr(A_MASK, 32'h0);
        chk_int(1'b1, 1'b1, 32'h0000_0110);
        tick();
        chk_int(1'b1, 1'b1, 32'h0000_0110);
        ack();
        wr(A_EOI, 32'h0);

        // 5: set beats a same-cycle W1C, plain W1C clears
        irq_src = 8'h02;
        tick();
        irq_src = 8'h00;
        tick();
        irq_src = 8'h02;
        wr(A_PEND, 32'h0000_0002);
        irq_src = 8'h00;
        rd(A_PEND, 32'h0000_0002);
        tick();
        wr(A_PEND, 32'h0000_0002);
        rd(A_PEND, 32'h0);

        // 6: held-high source across ack+EOI
        wr(A_MASK, 32'h0000_0001);
        vec_q.push_back(32'h0000_0100);
        irq_src = 8'h01;
        wait_int("t6_req");
        ack();
        if (!EDGE) vec_q.push_back(32'h0000_0100);
        wr(A_EOI, 32'h0);
        repeat (3) tick();
        chk_int(!EDGE, 1'b0, 32'h0);

        // 7: reset while in SERVICE
        irq_src = 8'h00;
        tick();
        if (EDGE) begin
            vec_q.push_back(32'h0000_0100);
            irq_src = 8'h01;
            tick();
            irq_src = 8'h00;
            wait_int("t7_req");
        end
        ack();
        rd(A_INSV, 32'h0000_0001);
        reset = 1'b0;
        #1;
        chk_int(1'b0, 1'b1, 32'h0000_0100);
        rd(A_INSV, 32'h0);
        rd(A_MASK, 32'h0);
        tick();
        reset = 1'b1;
        wr(A_MASK, 32'h0000_0080);
        vec_q.push_back(32'h0000_011C);
        irq_src = 8'h80;
        tick();
        irq_src = 8'h00;
        wait_int("t7_after_reset");
        ack();
        wr(A_EOI, 32'h0);
        repeat (3) tick();

        // Every issued expectation must have been consumed.
        n_cmp++;
        if (rd_q.size() != 0 || vec_q.size() != 0 || probe_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got rd=%0d vec=%0d probe=%0d left want 0",
                     rd_q.size(), vec_q.size(), probe_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
